// File: rtl/hazard_pkg.sv
// Shared constants and mode type for the hazard-light front end and state machine.
package hazard_pkg;

  localparam int HAZ_CLK_HZ    = 50_000_000;
  localparam int HAZ_STEP_HZ   = 1;
  localparam int HAZ_DB_MS     = 10;

  localparam int HAZ_DIV       = HAZ_CLK_HZ / HAZ_STEP_HZ;
  localparam int HAZ_DB_CYCLES = (HAZ_CLK_HZ / 1000) * HAZ_DB_MS;

  typedef logic [1:0] sw_mode_t;

endpackage

// File: rtl/hazard_input_conditioner_debounce_bit.sv
// One switch bit: 2-flop synchronizer followed by a stability-count debouncer.
// The counter exists only when HAZARD_DEBOUNCE_EN is defined; otherwise sync2 is registered directly.
module debounce_bit
  import hazard_pkg::*;
#(
  parameter int DB_CYCLES = HAZ_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_upd
);

  if (DB_CYCLES < 1) begin : g_db_chk
    $error("debounce_bit: DB_CYCLES must be >= 1");
  end

  logic r_sync1;
  logic r_sync2;
  logic r_clean;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef HAZARD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;

  // The DB_CYCLES-th consecutive differing cycle commits the new value.
  assign w_hit = (r_sync2 != r_clean) && (r_cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else if (r_sync2 == r_clean) begin
      r_cnt   <= '0;
    end else if (w_hit) begin
      r_cnt   <= '0;
      r_clean <= r_sync2;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_upd = w_hit;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clean <= 1'b0;
    end else begin
      r_clean <= r_sync2;
    end
  end

  assign o_upd = (r_sync2 != r_clean);
`endif

  assign o_clean = r_clean;

endmodule

// File: rtl/hazard_input_conditioner.sv
// Conditions the two raw hazard switches and generates the pattern step enable.
// Debouncing is compiled in only when HAZARD_DEBOUNCE_EN is defined.
module hazard_input_conditioner
  import hazard_pkg::*;
#(
  parameter int DIV       = HAZ_DIV,
  parameter int DB_CYCLES = HAZ_DB_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw_clean,
  output logic       sw_change,
  output logic       step
);

  localparam int CNT_W = $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("hazard_input_conditioner: DIV must be >= 2");
  end

  sw_mode_t         w_clean;
  logic [1:0]       w_upd;
  logic             w_any_upd;
  logic             w_terminal;
  logic [CNT_W-1:0] r_div_cnt;
  logic             r_change;
  logic             r_step;

  for (genvar i = 0; i < 2; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (sw_raw[i]),
      .o_clean (w_clean[i]),
      .o_upd   (w_upd[i])
    );
  end

  assign w_any_upd  = |w_upd;
  assign w_terminal = (r_div_cnt == CNT_W'(DIV - 1));

  // A mode update restarts the period, but a coincident terminal count still emits its step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_change  <= 1'b0;
      r_step    <= 1'b0;
    end else begin
      r_change  <= w_any_upd;
      r_step    <= w_terminal;
      r_div_cnt <= (w_terminal || w_any_upd) ? '0 : r_div_cnt + CNT_W'(1);
    end
  end

  assign sw_clean  = w_clean;
  assign sw_change = r_change;
  assign step      = r_step;

endmodule

// File: tb/tb_hazard_input_conditioner.sv
// Directed plus randomized bench for hazard_input_conditioner (DIV=8, DB_CYCLES=4).
module tb_hazard_input_conditioner;

  localparam int DIV = 8;
  localparam int DB  = 4;
`ifdef HAZARD_DEBOUNCE_EN
  localparam int W = DB;
`else
  localparam int W = 1;
`endif
  localparam int LAT = W + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_clean;
  logic       sw_change;
  logic       step;

  hazard_input_conditioner #(
    .DIV       (DIV),
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_change (sw_change),
    .step      (step)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         k;
  int         restart;
  logic [1:0] raw_at [0:8191];
  logic [1:0] m_clean;
  logic       m_change;
  logic       m_step;
  logic [1:0] cur;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic check_all();
    check("sw_clean", sw_clean, m_clean);
    check("sw_change", {1'b0, sw_change}, {1'b0, m_change});
    check("step", {1'b0, step}, {1'b0, m_step});
  endtask

  task automatic model_reset();
    k        = 0;
    restart  = 0;
    m_clean  = 2'b00;
    m_change = 1'b0;
    m_step   = 1'b0;
  endtask

  // Synchronized sample seen at edge m is the raw value taken two edges earlier (zero after reset).
  function automatic logic samp(input int m, input int b);
    if (m < 3) return 1'b0;
    return raw_at[m-2][b];
  endfunction

  // Apply raw for one clock; the model accepts a bit once the last W samples all disagree with it.
  task automatic cyc(input logic [1:0] raw);
    logic [1:0] nxt;
    logic       upd;
    logic       all_diff;
    sw_raw = raw;
    cur    = raw;
    @(posedge clk);
    k++;
    raw_at[k] = raw;
    nxt = m_clean;
    upd = 1'b0;
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int m = k - W + 1; m <= k; m++)
        if (samp(m, b) == m_clean[b]) all_diff = 1'b0;
      if (all_diff) begin
        nxt[b] = ~m_clean[b];
        upd    = 1'b1;
      end
    end
    m_step   = ((k - restart) % DIV) == 0;
    if (upd) restart = k;
    m_change = upd;
    m_clean  = nxt;
    #1;
    check_all();
  endtask

  task automatic hold(input logic [1:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw);
  endtask

  // Async reset asserted away from the clock edge; outputs must clear at once and stay clear.
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    for (int i = 0; i < cycles; i++) begin
      sw_raw = ~sw_raw;
      @(posedge clk);
      #1;
      check_all();
    end
    sw_raw = cur;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset(3);

    hold(2'b00, 20);
    hold(2'b01, 15);
    hold(2'b00, 15);
    hold(2'b01, 3);
    hold(2'b00, 15);
    hold(2'b11, 15);
    hold(2'b00, 12);

    // Line the next mode change up with a terminal-count edge.
    for (int g = 0; g < DIV && ((k + 1 + LAT - restart) % DIV) != 0; g++) cyc(2'b00);
    hold(2'b10, 20);

    hold(2'b01, 5);
    do_reset(2);
    hold(2'b01, 20);

    for (int s = 0; s < 300; s++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      hold(v, $urandom_range(1, 7));
    end
    hold(2'b00, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
